// File: rtl/sdr_wb_arb_pkg.sv
// Shared types and constants for the two-master SDRAM Wishbone arbiter.
package sdr_wb_arb_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int WDOG_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ERR  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdr_wb_rr_pick.sv
// Round-robin pick between two requesters: on contention the master that was not served last wins.
module sdr_wb_rr_pick
    import sdr_wb_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] request,
    input  logic                   lst,
    output logic [NUM_MASTERS-1:0] pick
);

    always_comb begin
        pick = '0;
        if (request == 2'b11) begin
            pick = lst ? 2'b01 : 2'b10;
        end else begin
            pick = request;
        end
    end

endmodule

// File: rtl/sdr_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller slave port.
// Optional bus watchdog enabled by defining SDR_WB_ARB_TIMEOUT_EN.
module sdr_wb_arbiter
    import sdr_wb_arb_pkg::*;
#(
    parameter int AW          = 26,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic [NUM_MASTERS-1:0]   m_cyc_i,
    input  logic [NUM_MASTERS-1:0]   m_stb_i,
    input  logic [NUM_MASTERS-1:0]   m_we_i,
    input  logic [2*(DW/8)-1:0]      m_sel_i,
    input  logic [2*AW-1:0]          m_adr_i,
    input  logic [2*DW-1:0]          m_dat_i,
    output logic [NUM_MASTERS-1:0]   m_ack_o,
    output logic [NUM_MASTERS-1:0]   m_err_o,
    output logic [DW-1:0]            m_dat_o,
    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [DW/8-1:0]          s_sel_o,
    output logic [AW-1:0]            s_adr_o,
    output logic [DW-1:0]            s_dat_o,
    input  logic                     s_ack_i,
    input  logic [DW-1:0]            s_dat_i
);

    localparam int SW = DW / 8;

    arb_state_t             state;
    logic [NUM_MASTERS-1:0] gnt;
    logic                   lst;
    logic [NUM_MASTERS-1:0] pick;
    logic                   busy;
    logic                   ack_ok;
    logic                   gnt_cyc;
    logic                   timeout;

    sdr_wb_rr_pick u_pick (
        .request (m_cyc_i),
        .lst     (lst),
        .pick    (pick)
    );

    assign busy    = (state == BUSY);
    assign gnt_cyc = |(m_cyc_i & gnt);

    // Slave-side signals derive from the async-reset state, so reset drops them immediately.
    always_comb begin
        s_cyc_o = busy;
        s_stb_o = busy & (gnt[1] ? m_stb_i[1] : m_stb_i[0]);
        s_we_o  = busy & (gnt[1] ? m_we_i[1]  : m_we_i[0]);
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (busy) begin
            s_sel_o = gnt[1] ? m_sel_i[2*SW-1:SW] : m_sel_i[SW-1:0];
            s_adr_o = gnt[1] ? m_adr_i[2*AW-1:AW] : m_adr_i[AW-1:0];
            s_dat_o = gnt[1] ? m_dat_i[2*DW-1:DW] : m_dat_i[DW-1:0];
        end
    end

    assign ack_ok  = s_ack_i & s_stb_o;
    assign m_ack_o = gnt & {NUM_MASTERS{ack_ok}};
    assign m_dat_o = s_dat_i;

`ifdef SDR_WB_ARB_TIMEOUT_EN
    logic [WDOG_W-1:0] wdog;

    // Error fires in the stalled cycle that would bring the count to TIMEOUT_CYC.
    assign timeout = s_stb_o & ~s_ack_i & (wdog == WDOG_W'(TIMEOUT_CYC - 1));
    assign m_err_o = gnt & {NUM_MASTERS{timeout}};

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wdog <= '0;
        end else if (s_stb_o && !s_ack_i) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end
`else
    assign timeout = 1'b0;
    assign m_err_o = '0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            gnt   <= '0;
            lst   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_cyc_i) begin
                        state <= BUSY;
                        gnt   <= pick;
                    end
                end
                BUSY: begin
                    if (!gnt_cyc) begin
                        state <= IDLE;
                        lst   <= gnt[1];
                        gnt   <= '0;
                    end else if (timeout) begin
                        state <= ERR;
                    end
                end
                ERR: begin
                    if (!gnt_cyc) begin
                        state <= IDLE;
                        lst   <= gnt[1];
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdr_wb_arbiter.sv
// Scoreboard bench for sdr_wb_arbiter: queued master transactions, zero-wait slave, per-ack checks.
module tb_sdr_wb_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int SW = DW / 8;
`ifdef SDR_WB_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    m_cyc, m_stb, m_we, m_ack, m_err;
    logic [2*SW-1:0] m_sel;
    logic [2*AW-1:0] m_adr;
    logic [2*DW-1:0] m_dat;
    logic [DW-1:0] m_rdat;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [SW-1:0] s_sel;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_wdat, s_rdat;

    always #5 clk = ~clk;

    sdr_wb_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYC(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_we_i   (m_we),
        .m_sel_i  (m_sel),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_ack_o  (m_ack),
        .m_err_o  (m_err),
        .m_dat_o  (m_rdat),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_we_o   (s_we),
        .s_sel_o  (s_sel),
        .s_adr_o  (s_adr),
        .s_dat_o  (s_wdat),
        .s_ack_i  (s_ack),
        .s_dat_i  (s_rdat)
    );

    typedef struct { logic [AW-1:0] adr; int unsigned beats; bit we; } txn_t;
    typedef struct { int unsigned m; logic [AW-1:0] adr; bit we; } exp_t;

    txn_t mq0[$], mq1[$];
    exp_t sb[$];

    int unsigned vec_cnt = 0, err_cnt = 0, pop_cnt = 0;
    bit ack_en, stray, abort;
    bit busy[2], gap[2], acked[2], cwe[2];
    int unsigned left[2];
    logic [AW-1:0] cadr[2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mdat(input int unsigned m, input logic [AW-1:0] a);
        return DW'(a) ^ ((m == 1) ? 32'hBBBB_0000 : 32'hAAAA_0000);
    endfunction

    function automatic logic [DW-1:0] sdat(input logic [AW-1:0] a);
        return DW'(a) ^ 32'h5A5A_0000;
    endfunction

    task automatic push_txn(input int unsigned m, input logic [AW-1:0] a, input int unsigned n, input bit we);
        txn_t t;
        exp_t e;
        t.adr = a; t.beats = n; t.we = we;
        if (m == 0) mq0.push_back(t); else mq1.push_back(t);
    endtask

    task automatic expect_beats(input int unsigned m, input logic [AW-1:0] a, input int unsigned n, input bit we);
        exp_t e;
        for (int unsigned i = 0; i < n; i++) begin
            e.m = m; e.adr = a + AW'(4 * i); e.we = we;
            sb.push_back(e);
        end
    endtask

    // Master driver: both masters from one process, acting 1 time unit after each rising edge.
    initial begin
        txn_t t;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0;
        m_sel = {4'h3, 4'hF};
        for (int i = 0; i < 2; i++) begin
            busy[i] = 0; gap[i] = 0; left[i] = 0; cadr[i] = '0; cwe[i] = 0;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int m = 0; m < 2; m++) begin
                if (rst || abort) begin
                    busy[m] = 0; gap[m] = 0;
                end else if (busy[m] && acked[m]) begin
                    left[m]--;
                    cadr[m] = cadr[m] + AW'(4);
                    if (left[m] == 0) begin busy[m] = 0; gap[m] = 1; end
                end else if (gap[m]) begin
                    gap[m] = 0;
                end
                if (!rst && !abort && !busy[m] && !gap[m]) begin
                    if (m == 0 && mq0.size() != 0) begin
                        t = mq0.pop_front(); busy[m] = 1; left[m] = t.beats; cadr[m] = t.adr; cwe[m] = t.we;
                    end else if (m == 1 && mq1.size() != 0) begin
                        t = mq1.pop_front(); busy[m] = 1; left[m] = t.beats; cadr[m] = t.adr; cwe[m] = t.we;
                    end
                end
                m_cyc[m] = busy[m];
                m_stb[m] = busy[m];
                m_we[m]  = busy[m] & cwe[m];
                m_adr[m*AW +: AW] = cadr[m];
                m_dat[m*DW +: DW] = mdat(m, cadr[m]);
            end
        end
    end

    // Zero-wait slave
    initial begin
        s_ack = 1'b0; s_rdat = '0;
        forever begin
            @(posedge clk);
            #2;
            s_ack  = stray | (ack_en & s_cyc & s_stb);
            s_rdat = sdat(s_adr);
        end
    end

    // Monitor: every accepted ack must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        acked[0] = m_ack[0];
        acked[1] = m_ack[1];
        if (!rst && s_ack) begin
            if (s_stb) begin
                if (sb.size() == 0) begin
                    check_eq("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    pop_cnt++;
                    check_eq("ack_map", m_ack, (e.m == 1) ? 2'b10 : 2'b01);
                    check_eq("adr",  s_adr, e.adr);
                    check_eq("we",   s_we, e.we);
                    check_eq("sel",  s_sel, (e.m == 1) ? 4'h3 : 4'hF);
                    check_eq("wdat", s_wdat, mdat(e.m, e.adr));
                    check_eq("rdat", m_rdat, sdat(e.adr));
                end
            end else begin
                check_eq("stray_ack", m_ack, 2'b00);
            end
        end
    end

    task automatic wait_done(input int unsigned budget, output int unsigned idle);
        bit started;
        started = 0;
        idle = 0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (s_cyc) started = 1;
            else if (started) idle++;
            if (sb.size() == 0 && mq0.size() == 0 && mq1.size() == 0 && !busy[0] && !busy[1]) return;
        end
        check_eq("timeout_sb_left", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int unsigned idle, base, stalls, err_at;
        logic [1:0] err_val;
        rst = 1'b1; ack_en = 1; stray = 0; abort = 0;
        repeat (3) @(negedge clk);

        // Reset state, with a stray ack present
        stray = 1;
        repeat (2) @(negedge clk);
        check_eq("rst_cyc", s_cyc, 0);
        check_eq("rst_stb", s_stb, 0);
        check_eq("rst_ack", m_ack, 0);
        check_eq("rst_err", m_err, 0);
        stray = 0;
        @(negedge clk); rst = 1'b0;

        // Stray ack while idle
        stray = 1;
        repeat (2) @(negedge clk);
        check_eq("idle_stray_ack", m_ack, 0);
        check_eq("idle_stray_cyc", s_cyc, 0);
        stray = 0;
        @(negedge clk);

        // One-cycle arbitration latency for a lone master 0
        push_txn(0, 26'h000_0100, 1, 1); expect_beats(0, 26'h000_0100, 1, 1);
        @(posedge clk); #3;
        check_eq("lat_edge1_cyc", s_cyc, 0);
        @(posedge clk); #3;
        check_eq("lat_edge2_cyc", s_cyc, 1);
        check_eq("lat_adr", s_adr, 26'h000_0100);
        check_eq("lat_ack", m_ack, 2'b01);
        wait_done(50, idle);

        // Contention: alternating grants, one idle cycle between each
        do_reset();
        push_txn(0, 26'h010_0000, 1, 1); push_txn(0, 26'h010_0010, 1, 0);
        push_txn(1, 26'h020_0000, 1, 0); push_txn(1, 26'h020_0010, 1, 1);
        expect_beats(0, 26'h010_0000, 1, 1); expect_beats(1, 26'h020_0000, 1, 0);
        expect_beats(0, 26'h010_0010, 1, 0); expect_beats(1, 26'h020_0010, 1, 1);
        wait_done(100, idle);
        check_eq("rr_idle_gaps", idle, 3);

        // Master 1 burst holds the grant against master 0
        push_txn(0, 26'h030_0000, 1, 0); expect_beats(0, 26'h030_0000, 1, 0);
        wait_done(50, idle);
        push_txn(1, 26'h040_0000, 4, 1); push_txn(0, 26'h050_0000, 1, 1);
        expect_beats(1, 26'h040_0000, 4, 1); expect_beats(0, 26'h050_0000, 1, 1);
        wait_done(100, idle);
        check_eq("burst_idle_gaps", idle, 1);

        // Stalled slave
        ack_en = 0;
        push_txn(0, 26'h060_0000, 1, 0);
`ifdef SDR_WB_ARB_TIMEOUT_EN
        stalls = 0; err_at = 0; err_val = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (s_cyc && s_stb) stalls++;
            if (m_err != 2'b00) begin err_at = stalls; err_val = m_err; break; end
        end
        check_eq("tmo_cycle", err_at, 8);
        check_eq("tmo_err", err_val, 2'b01);
        @(negedge clk);
        check_eq("tmo_pulse_len", m_err, 0);
        repeat (3) @(negedge clk);
        check_eq("tmo_cyc_held_low", s_cyc, 0);
        abort = 1;
        repeat (2) @(negedge clk);
        abort = 0;
        ack_en = 1;
        push_txn(0, 26'h068_0000, 1, 1); expect_beats(0, 26'h068_0000, 1, 1);
        wait_done(50, idle);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_eq("stall_no_err", m_err, 0);
        end
        check_eq("stall_hold_cyc", s_cyc, 1);
        expect_beats(0, 26'h060_0000, 1, 0);
        ack_en = 1;
        wait_done(50, idle);
`endif

        // Reset in the middle of a master 1 burst
        base = pop_cnt;
        push_txn(1, 26'h070_0000, 4, 1); expect_beats(1, 26'h070_0000, 4, 1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk); #1;
            if (pop_cnt >= base + 2) break;
        end
        check_eq("burst_progress", pop_cnt - base, 2);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_cyc", s_cyc, 0);
        check_eq("mid_rst_stb", s_stb, 0);
        check_eq("mid_rst_ack", m_ack, 0);
        check_eq("mid_rst_err", m_err, 0);
        sb.delete(); mq0.delete(); mq1.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push_txn(0, 26'h080_0000, 1, 0); push_txn(1, 26'h090_0000, 1, 1);
        expect_beats(0, 26'h080_0000, 1, 0); expect_beats(1, 26'h090_0000, 1, 1);
        wait_done(60, idle);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sdr_wb_arbiter.md
SDR_WB_ARBITER -- requirements
Module: sdr_wb_arbiter

Interface
REQ-001 SHALL have parameter AW, default 26, meaning the Wishbone address width per master.
REQ-002 SHALL have parameter DW, default 32, meaning the Wishbone data width; byte selects are DW/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, meaning the watchdog limit in wb_clk_i cycles; legal range 1..255.
REQ-004 SHALL have port wb_clk_i, input, 1, the single clock for all logic.
REQ-005 SHALL have port wb_rst_i, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have ports m_cyc_i / m_stb_i / m_we_i, input, 2 each, per-master Wishbone controls (bit n = master n).
REQ-007 SHALL have ports m_sel_i, m_adr_i, m_dat_i, input, 2*DW/8, 2*AW and 2*DW respectively, packed per master, master 0 in the LSBs.
REQ-008 SHALL have ports m_ack_o / m_err_o, output, 2 each, per-master acknowledge and error; also m_dat_o, output, DW, shared read data.
REQ-009 SHALL have ports s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, output, widths 1/1/1/DW/8/AW/DW, toward the SDRAM controller Wishbone slave.
REQ-010 SHALL have ports s_ack_i, input, 1, and s_dat_i, input, DW, from the slave.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY and ERR, plus a registered one-hot grant gnt[1:0] and a last-served pointer lst.
REQ-012 IDLE: gnt=00 and all s_* controls are 0; when any m_cyc_i is set, the next edge SHALL enter BUSY with gnt chosen round-robin (priority to the master != lst; a lone requester wins).
REQ-013 BUSY: s_cyc_o=1; s_stb_o, s_we_o, s_sel_o, s_adr_o and s_dat_o SHALL be a combinational mux of the granted master's inputs.
REQ-014 m_ack_o[g]=s_ack_i & gnt[g] combinationally; the non-granted master SHALL never see ack or err; m_dat_o=s_dat_i always.
REQ-015 Arbitration latency SHALL be exactly 1 cycle from m_cyc_i rise to s_cyc_o rise.
REQ-016 The grant SHALL be held while the granted m_cyc_i=1, covering multi-beat and RMW cycles; no preemption.
REQ-017 When the granted m_cyc_i falls: the next edge SHALL go to IDLE, set lst to the granted index and clear gnt; there is always at least 1 IDLE cycle between grants.
REQ-018 Simultaneous requests in IDLE: the grant SHALL go to the master != lst; after reset lst=1, so master 0 wins first.
REQ-019 An s_ack_i arriving while s_stb_o=0 SHALL be ignored and not forwarded.

Reset
REQ-020 While wb_rst_i=1: state=IDLE, gnt=00, lst=1, watchdog=0; m_ack_o, m_err_o and all s_* control outputs SHALL be 0.
REQ-021 Reset asserted mid-BUSY SHALL drop s_cyc_o/s_stb_o asynchronously in the same cycle; nothing is replayed after release.
REQ-022 After wb_rst_i falls, the first grant SHALL occur no earlier than the first edge at which m_cyc_i is sampled high.

Configuration
REQ-023 Macro SDR_WB_ARB_TIMEOUT_EN SHALL select the watchdog.
REQ-024 Defined: an 8-bit counter increments each BUSY cycle with s_stb_o=1 & s_ack_i=0 and clears on ack or on leaving BUSY.
REQ-025 Defined: when the counter reaches TIMEOUT_CYC, the arbiter SHALL pulse m_err_o[g] for 1 cycle, enter ERR (s_cyc_o=s_stb_o=0) and wait in ERR until m_cyc_i[g]=0, then go to IDLE and update lst.
REQ-026 Undefined: no counter and no ERR state; m_err_o is tied to 00.

Structure
REQ-027 Shared package sdr_wb_arb_pkg SHALL hold the state enum, NUM_MASTERS=2 and the watchdog counter width (8).
REQ-028 One sub-module, sdr_wb_rr_pick (request[1:0], lst -> one-hot pick), combinational; the FSM, mux and watchdog stay in the top level.

Verification
REQ-029 Reset release, then m_cyc_i=01 -> s_cyc_o=1 on the 2nd edge; s_adr_o = master 0 address; m_ack_o=01 on s_ack_i.
REQ-030 m_cyc_i=11 held for 4 back-to-back single transactions -> grants in the order 0,1,0,1, each separated by 1 IDLE cycle.
REQ-031 Master 1 4-beat burst with m_cyc_i=11 -> gnt=10 for all 4 acks; master 0 sees no ack; master 0 granted next.
REQ-032 With the macro defined and TIMEOUT_CYC=8, s_ack_i stuck 0 -> m_err_o[g] pulses in the 8th stalled cycle, then s_cyc_o=0 until the master drops cyc.
REQ-033 wb_rst_i asserted mid-burst -> s_cyc_o=0 in the same cycle, all outputs 0; after release with m_cyc_i=11, master 0 is granted.
REQ-034 Stray s_ack_i in IDLE -> m_ack_o stays 00.
